// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: per channel a 2-FF synchronizer, a debounce FSM,
// a registered clean level and one-cycle press/release pulses.
module btn_debounce_pulse #(
    parameter int NUM_BTN       = 2,
    parameter int STABLE_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    logic [NUM_BTN-1:0] sync_p0;
    logic [NUM_BTN-1:0] sync_p1;

    // Stage boundary: raw asynchronous inputs -> two-flop synchronizer
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            state_t           state;
            logic [CNT_W-1:0] cnt;
            logic             level;
            logic             press;
            logic             rel;

            // Stage boundary: synchronized level -> debounce FSM with registered outputs
            always_ff @(posedge clk) begin
                if (rst) begin
                    state <= RELEASED;
                    cnt   <= '0;
                    level <= 1'b0;
                    press <= 1'b0;
                    rel   <= 1'b0;
                end else begin
                    press <= 1'b0;
                    rel   <= 1'b0;
                    case (state)
                        RELEASED: begin
                            if (sync_p1[gi]) begin
                                state <= PRESS_CHK;
                                cnt   <= CNT_W'(1);
                            end else begin
                                cnt <= '0;
                            end
                        end
                        PRESS_CHK: begin
                            if (!sync_p1[gi]) begin
                                state <= RELEASED;
                                cnt   <= '0;
                            end else if (cnt == CNT_LAST) begin
                                state <= PRESSED;
                                cnt   <= '0;
                                level <= 1'b1;
                                press <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        PRESSED: begin
                            if (!sync_p1[gi]) begin
                                state <= RELEASE_CHK;
                                cnt   <= CNT_W'(1);
                            end else begin
                                cnt <= '0;
                            end
                        end
                        RELEASE_CHK: begin
                            if (sync_p1[gi]) begin
                                state <= PRESSED;
                                cnt   <= '0;
                            end else if (cnt == CNT_LAST) begin
                                state <= RELEASED;
                                cnt   <= '0;
                                level <= 1'b0;
                                rel   <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                        default: begin
                            state <= RELEASED;
                            cnt   <= '0;
                        end
                    endcase
                end
            end

            assign btn_level[gi]   = level;
            assign btn_press[gi]   = press;
            assign btn_release[gi] = rel;
        end
    endgenerate

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: scenario tasks plus random bouncing, checked
// against a sliding-window model of the debounced level.
module tb_btn_debounce_pulse;

    localparam int NB = 2;
    localparam int SC = 4;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    int checks = 0;
    int errors = 0;

    btn_debounce_pulse #(.NUM_BTN(NB), .STABLE_CYCLES(SC)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: two-sample input delay, then the level flips once the last SC
    // delayed samples (since reset or the previous flip) all disagree with it.
    logic [NB-1:0] m_s1, m_s2, m_level, m_press, m_rel;
    bit            hist [NB][$];

    task automatic cycle(input logic [NB-1:0] raw, input logic r);
        logic [NB-1:0] s2_old;
        bit            all_diff;
        btn_raw = raw;
        rst     = r;
        @(posedge clk);
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
            for (int c = 0; c < NB; c++) hist[c].delete();
        end else begin
            s2_old  = m_s2;
            m_press = '0;
            m_rel   = '0;
            for (int c = 0; c < NB; c++) begin
                hist[c].push_back(s2_old[c]);
                if (hist[c].size() > SC) void'(hist[c].pop_front());
                all_diff = (hist[c].size() == SC);
                for (int k = 0; k < hist[c].size(); k++)
                    if (hist[c][k] == m_level[c]) all_diff = 0;
                if (all_diff) begin
                    if (m_level[c]) m_rel[c] = 1'b1;
                    else m_press[c] = 1'b1;
                    m_level[c] = ~m_level[c];
                    hist[c].delete();
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int pe0 = 0, pe1 = 0, pc = 0;
        for (int e = 1; e <= 3; e++) begin
            cycle(2'b11, 1'b1);
            checks++;
            if ({btn_level, btn_press, btn_release} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs edge %0d got lvl=%b prs=%b rel=%b want all 0",
                         e, btn_level, btn_press, btn_release);
            end
        end
        for (int e = 1; e <= 9; e++) begin
            cycle(2'b11, 1'b0);
            checks++;
            if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_rel}) begin
                errors++;
                $display("FAIL reset_release_model edge %0d got %b/%b/%b want %b/%b/%b", e,
                         btn_level, btn_press, btn_release, m_level, m_press, m_rel);
            end
            if (btn_press[0]) begin pe0 = e; pc++; end
            if (btn_press[1]) begin pe1 = e; pc++; end
        end
        checks++;
        if (pe0 != 6 || pe1 != 6 || pc != 2 || btn_level !== 2'b11) begin
            errors++;
            $display("FAIL reset_held_press got edges %0d,%0d count %0d lvl=%b want 6,6 count 2 lvl=11",
                     pe0, pe1, pc, btn_level);
        end
    endtask

    task automatic test_press();
        int pe = 0, pc = 0, rc = 0;
        cycle(2'b00, 1'b1);
        for (int e = 0; e < 3; e++) cycle(2'b00, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            cycle(2'b01, 1'b0);
            checks++;
            if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_rel}) begin
                errors++;
                $display("FAIL press_model edge %0d got %b/%b/%b want %b/%b/%b", e,
                         btn_level, btn_press, btn_release, m_level, m_press, m_rel);
            end
            if (btn_press[0]) begin pe = e; pc++; end
            if (btn_release[0]) rc++;
        end
        checks++;
        if (pe != 6 || pc != 1 || rc != 0 || btn_level[0] !== 1'b1) begin
            errors++;
            $display("FAIL press_latency got edge %0d presses %0d releases %0d lvl %b want 6,1,0,1",
                     pe, pc, rc, btn_level[0]);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat = 5'b10101;
        int pe = 0, pc = 0, rc = 0;
        cycle(2'b00, 1'b1);
        for (int e = 0; e < 3; e++) cycle(2'b00, 1'b0);
        for (int i = 4; i >= 1; i--) begin
            cycle({1'b0, pat[i]}, 1'b0);
            checks++;
            if (btn_press !== 2'b00 || btn_level !== 2'b00) begin
                errors++;
                $display("FAIL bounce_early got prs=%b lvl=%b want 00/00", btn_press, btn_level);
            end
        end
        for (int e = 1; e <= 10; e++) begin
            cycle(2'b01, 1'b0);
            checks++;
            if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_rel}) begin
                errors++;
                $display("FAIL bounce_model edge %0d got %b/%b/%b want %b/%b/%b", e,
                         btn_level, btn_press, btn_release, m_level, m_press, m_rel);
            end
            if (btn_press[0]) begin pe = e; pc++; end
            if (btn_release[0]) rc++;
        end
        checks++;
        if (pe != 6 || pc != 1 || rc != 0) begin
            errors++;
            $display("FAIL bounce_single_press got edge %0d presses %0d releases %0d want 6,1,0",
                     pe, pc, rc);
        end
    endtask

    task automatic test_glitch();
        int hits = 0;
        cycle(2'b00, 1'b1);
        for (int e = 0; e < 3; e++) cycle(2'b00, 1'b0);
        for (int e = 1; e <= 14; e++) begin
            cycle((e <= 3) ? 2'b01 : 2'b00, 1'b0);
            if (btn_level[0] || btn_press[0] || btn_release[0]) hits++;
        end
        checks++;
        if (hits != 0 || m_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject got %0d active cycles, model lvl %b want 0,0", hits, m_level[0]);
        end
    endtask

    task automatic test_simultaneous();
        int re0 = 0, pe1 = 0, other = 0;
        cycle(2'b00, 1'b1);
        for (int e = 0; e < 9; e++) cycle(2'b01, 1'b0);
        checks++;
        if (btn_level !== 2'b01) begin
            errors++;
            $display("FAIL simul_setup got lvl=%b want 01", btn_level);
        end
        for (int e = 1; e <= 10; e++) begin
            cycle(2'b10, 1'b0);
            checks++;
            if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_rel}) begin
                errors++;
                $display("FAIL simul_model edge %0d got %b/%b/%b want %b/%b/%b", e,
                         btn_level, btn_press, btn_release, m_level, m_press, m_rel);
            end
            if (btn_release[0]) re0 = e;
            if (btn_press[1]) pe1 = e;
            if (btn_press[0] || btn_release[1]) other++;
        end
        checks++;
        if (re0 != 6 || pe1 != 6 || other != 0 || btn_level !== 2'b10) begin
            errors++;
            $display("FAIL simul_pulses got rel0 %0d prs1 %0d stray %0d lvl %b want 6,6,0,10",
                     re0, pe1, other, btn_level);
        end
    endtask

    task automatic test_reset_mid();
        int pe = 0, early = 0;
        cycle(2'b00, 1'b1);
        for (int e = 0; e < 3; e++) cycle(2'b00, 1'b0);
        for (int e = 1; e <= 4; e++) begin
            cycle(2'b01, 1'b0);
            if (btn_press[0] || btn_level[0]) early++;
        end
        cycle(2'b01, 1'b1);
        checks++;
        if (early != 0 || {btn_level, btn_press, btn_release} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_clear got early %0d lvl=%b prs=%b want 0 and zeros",
                     early, btn_level, btn_press);
        end
        for (int e = 1; e <= 9; e++) begin
            cycle(2'b01, 1'b0);
            if (btn_press[0]) pe = (pe == 0) ? e : -1;
        end
        checks++;
        if (pe != 6) begin
            errors++;
            $display("FAIL midreset_press got edge %0d want 6", pe);
        end
    endtask

    task automatic test_random();
        logic [NB-1:0] raw = '0;
        int pulses = 0;
        cycle(2'b00, 1'b1);
        for (int e = 0; e < 600; e++) begin
            for (int c = 0; c < NB; c++) begin
                // Mostly hold, sometimes flip: yields both bounces and accepted edges
                if ($urandom_range(0, 5) == 0) raw[c] = ~raw[c];
            end
            cycle(raw, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
            checks++;
            if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_rel}
                || (btn_press & btn_release) !== '0) begin
                errors++;
                $display("FAIL random_model cycle %0d got %b/%b/%b want %b/%b/%b", e,
                         btn_level, btn_press, btn_release, m_level, m_press, m_rel);
            end
            pulses += $countones(m_press | m_rel);
        end
        checks++;
        if (pulses < 4) begin
            errors++;
            $display("FAIL random_activity got %0d model pulses want >= 4", pulses);
        end
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = '0;
        m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
        @(negedge clk);
        test_reset();
        test_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
